// File: rtl/mips_hazard_pkg.sv
// Shared definitions for the decode-stage hazard unit.
//   - Legal ranges for the FWD_STAGES / LOAD_LAT parameters.
//   - sb_entry_t: one scoreboard slot describing an in-flight producer.
//   - link_state_e: load-link reservation states.
//   - sat_inc(): saturating increment for the stall counter.
package mips_hazard_pkg;

  localparam int unsigned FwdStagesMin = 1;
  localparam int unsigned FwdStagesMax = 4;
  localparam int unsigned LoadLatMin   = 1;

  // Scoreboard destination field is sized for the widest supported register address.
  localparam int unsigned SbAddrW = 8;
  localparam int unsigned CntW    = 32;

  typedef struct packed {
    logic               valid;
    logic               is_load;
    logic [SbAddrW-1:0] dest;
  } sb_entry_t;

  typedef enum logic [0:0] {
    StIdle,
    StLinked
  } link_state_e;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + {{(CntW-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register.
// Scans the scoreboard for the youngest in-flight producer of src_addr_i and
// returns that stage's result, or the register-file value when nothing matches.
// hazard_o flags a used source whose youngest producer is a load whose data is
// not yet available.
// Ports:
//   src_addr_i    source register address
//   src_used_i    instruction actually reads this source
//   rf_data_i     register-file read data
//   sb_i          scoreboard, index 0 = instruction in EX
//   stage_data_i  per-stage results, stage i at [i*DATA_W +: DATA_W]
//   data_o        forwarded operand
//   hazard_o      load-use hazard on this source
module fwd_mux
  import mips_hazard_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic [ADDR_W-1:0]            src_addr_i,
  input  logic                         src_used_i,
  input  logic [DATA_W-1:0]            rf_data_i,
  input  sb_entry_t [FWD_STAGES-1:0]   sb_i,
  input  logic [FWD_STAGES*DATA_W-1:0] stage_data_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         hazard_o
);

  logic [SbAddrW-1:0] src_ext;
  logic               src_nonzero;
  logic               hit;

  assign src_ext     = SbAddrW'(src_addr_i);
  assign src_nonzero = (src_addr_i != '0);

  always_comb begin
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    hit      = 1'b0;
    // First match from index 0 upward is the youngest producer.
    for (int unsigned i = 0; i < FWD_STAGES; i++) begin
      if (!hit && src_nonzero && sb_i[i].valid && (sb_i[i].dest == src_ext)) begin
        hit      = 1'b1;
        data_o   = stage_data_i[i*DATA_W +: DATA_W];
        hazard_o = src_used_i && sb_i[i].is_load && (i < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Decode-stage hazard unit: operand forwarding, load-use stall detection,
// stall-cycle counter and optional load-link/store-conditional tracking.
// Optional feature macro: HAZARD_LLSC_EN (defined -> link FSM present;
// undefined -> atomic_id_o and mem_sc_mask_id_o tied low, LL/SC flags ignored).
// Ports:
//   clk_i, rst_ni                clock, asynchronous active-low reset
//   id_valid_i                   decode slot holds a real instruction
//   id_rs_addr_i, id_rt_addr_i   source addresses
//   id_rs_used_i, id_rt_used_i   source actually read
//   id_rs_data_i, id_rt_data_i   register-file read data
//   id_dest_addr_i, id_reg_we_i  destination and write enable
//   id_is_load_i, id_is_ll_i, id_is_sc_i, id_is_store_i  instruction class
//   flush_i                      squash decode instruction this cycle
//   stage_data_i                 per-stage results (stage 0 = EX)
//   rs_data_o, rt_data_o         forwarded operands
//   stall_o                      hold decode and fetch
//   atomic_id_o                  load-link reservation active
//   mem_sc_mask_id_o             SC in decode must not store
//   stall_count_o                saturating stalled-cycle count
module hazard_unit
  import mips_hazard_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         id_valid_i,
  input  logic [ADDR_W-1:0]            id_rs_addr_i,
  input  logic [ADDR_W-1:0]            id_rt_addr_i,
  input  logic                         id_rs_used_i,
  input  logic                         id_rt_used_i,
  input  logic [DATA_W-1:0]            id_rs_data_i,
  input  logic [DATA_W-1:0]            id_rt_data_i,
  input  logic [ADDR_W-1:0]            id_dest_addr_i,
  input  logic                         id_reg_we_i,
  input  logic                         id_is_load_i,
  input  logic                         id_is_ll_i,
  input  logic                         id_is_sc_i,
  input  logic                         id_is_store_i,
  input  logic                         flush_i,
  input  logic [FWD_STAGES*DATA_W-1:0] stage_data_i,
  output logic [DATA_W-1:0]            rs_data_o,
  output logic [DATA_W-1:0]            rt_data_o,
  output logic                         stall_o,
  output logic                         atomic_id_o,
  output logic                         mem_sc_mask_id_o,
  output logic [CntW-1:0]              stall_count_o
);

  if (FWD_STAGES < FwdStagesMin || FWD_STAGES > FwdStagesMax) begin : g_bad_fwd_stages
    $error("hazard_unit: FWD_STAGES out of range");
  end
  if (LOAD_LAT < LoadLatMin || LOAD_LAT > FWD_STAGES) begin : g_bad_load_lat
    $error("hazard_unit: LOAD_LAT out of range");
  end
  if (ADDR_W > SbAddrW) begin : g_bad_addr_w
    $error("hazard_unit: ADDR_W wider than scoreboard dest field");
  end

  sb_entry_t [FWD_STAGES-1:0] sb_q, sb_d;
  logic [CntW-1:0]            stall_count_q, stall_count_d;
  logic                       hz_rs, hz_rt;
  logic                       issue;

  // ---------------------------------------------------------------------------
  // Forwarding / hazard detection, one mux per source
  // ---------------------------------------------------------------------------
  fwd_mux #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .FWD_STAGES(FWD_STAGES),
    .LOAD_LAT  (LOAD_LAT)
  ) u_fwd_rs (
    .src_addr_i  (id_rs_addr_i),
    .src_used_i  (id_rs_used_i),
    .rf_data_i   (id_rs_data_i),
    .sb_i        (sb_q),
    .stage_data_i(stage_data_i),
    .data_o      (rs_data_o),
    .hazard_o    (hz_rs)
  );

  fwd_mux #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .FWD_STAGES(FWD_STAGES),
    .LOAD_LAT  (LOAD_LAT)
  ) u_fwd_rt (
    .src_addr_i  (id_rt_addr_i),
    .src_used_i  (id_rt_used_i),
    .rf_data_i   (id_rt_data_i),
    .sb_i        (sb_q),
    .stage_data_i(stage_data_i),
    .data_o      (rt_data_o),
    .hazard_o    (hz_rt)
  );

  // During reset the scoreboard is empty, so stall is low without extra gating.
  assign stall_o = id_valid_i && !flush_i && (hz_rs || hz_rt);
  assign issue   = id_valid_i && !stall_o && !flush_i;

  // ---------------------------------------------------------------------------
  // Scoreboard shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    sb_d = sb_q;
    for (int unsigned i = FWD_STAGES - 1; i > 0; i--) begin
      sb_d[i] = sb_q[i-1];
    end
    // Stalled or flushed cycles push a bubble into EX.
    sb_d[0] = '0;
    if (issue) begin
      sb_d[0] = '{valid:   id_reg_we_i && (id_dest_addr_i != '0),
                  is_load: id_is_load_i,
                  dest:    SbAddrW'(id_dest_addr_i)};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall counter
  // ---------------------------------------------------------------------------
  assign stall_count_d = stall_o ? sat_inc(stall_count_q) : stall_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count_o = stall_count_q;

  // ---------------------------------------------------------------------------
  // Load-link reservation
  // ---------------------------------------------------------------------------
`ifdef HAZARD_LLSC_EN
  link_state_e link_q;

  // Only issued instructions move the FSM; flushed or stalled ones leave it alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      link_q <= StIdle;
    end else if (issue) begin
      unique case (link_q)
        StIdle:   if (id_is_ll_i) link_q <= StLinked;
        StLinked: if (id_is_sc_i || id_is_store_i) link_q <= StIdle;
        default:  link_q <= StIdle;
      endcase
    end
  end

  assign atomic_id_o      = (link_q == StLinked);
  // Uses the current state, i.e. before the SC's own transition takes effect.
  assign mem_sc_mask_id_o = id_is_sc_i && (link_q == StIdle);
`else
  logic unused_llsc;
  assign unused_llsc      = ^{id_is_ll_i, id_is_sc_i, id_is_store_i};
  assign atomic_id_o      = 1'b0;
  assign mem_sc_mask_id_o = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

`ifdef HAZARD_LLSC_EN
  localparam bit LLSC = 1'b1;
`else
  localparam bit LLSC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         id_valid, rs_used, rt_used, we, is_load, is_ll, is_sc, is_store, flush;
  logic [4:0]   rs_a, rt_a, dest;
  logic [31:0]  rs_rf, rt_rf;
  logic [127:0] sd;

  logic [31:0]  rs0, rt0, cnt0, rs1, rt1, cnt1;
  logic         stall0, atom0, mask0, stall1, atom1, mask1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.DATA_W(32), .ADDR_W(5), .FWD_STAGES(2), .LOAD_LAT(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs_addr_i(rs_a), .id_rt_addr_i(rt_a), .id_rs_used_i(rs_used), .id_rt_used_i(rt_used),
    .id_rs_data_i(rs_rf), .id_rt_data_i(rt_rf), .id_dest_addr_i(dest), .id_reg_we_i(we),
    .id_is_load_i(is_load), .id_is_ll_i(is_ll), .id_is_sc_i(is_sc), .id_is_store_i(is_store),
    .flush_i(flush), .stage_data_i(sd[63:0]), .rs_data_o(rs0), .rt_data_o(rt0),
    .stall_o(stall0), .atomic_id_o(atom0), .mem_sc_mask_id_o(mask0), .stall_count_o(cnt0)
  );

  hazard_unit #(.DATA_W(32), .ADDR_W(5), .FWD_STAGES(4), .LOAD_LAT(3)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
    .id_rs_addr_i(rs_a), .id_rt_addr_i(rt_a), .id_rs_used_i(rs_used), .id_rt_used_i(rt_used),
    .id_rs_data_i(rs_rf), .id_rt_data_i(rt_rf), .id_dest_addr_i(dest), .id_reg_we_i(we),
    .id_is_load_i(is_load), .id_is_ll_i(is_ll), .id_is_sc_i(is_sc), .id_is_store_i(is_store),
    .flush_i(flush), .stage_data_i(sd), .rs_data_o(rs1), .rt_data_o(rt1),
    .stall_o(stall1), .atomic_id_o(atom1), .mem_sc_mask_id_o(mask1), .stall_count_o(cnt1)
  );

  // Reference model: history of the last four decode slots (age 0 = most recent),
  // per DUT configuration. Index 0 = FWD_STAGES 2 / LOAD_LAT 1, index 1 = 4 / 3.
  int          fwd[2] = '{2, 4};
  int          lat[2] = '{1, 3};
  logic        mv[2][4];
  logic [4:0]  md[2][4];
  logic        ml[2][4];
  logic        mlink[2];
  logic [31:0] mcnt[2];
  logic        e_stall[2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) mv[d][i] = 1'b0;
      mlink[d] = 1'b0;
      mcnt[d]  = 32'd0;
    end
  endfunction

  // Youngest producer of register a within the forwarding window.
  function automatic void src_exp(input int d, input logic [4:0] a, input logic [31:0] rf,
                                  output logic [31:0] dat, output logic hz);
    logic found;
    found = 1'b0;
    dat   = rf;
    hz    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && i < fwd[d] && a != 5'd0 && mv[d][i] && md[d][i] == a) begin
        found = 1'b1;
        dat   = sd[i*32 +: 32];
        hz    = ml[d][i] && (i < lat[d]);
      end
    end
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, got, exp);
    end
  endtask

  task automatic rand_data();
    rs_rf = $urandom;
    rt_rf = $urandom;
    for (int k = 0; k < 4; k++) sd[k*32 +: 32] = $urandom;
  endtask

  task automatic instr(input logic v, input logic [4:0] dst, input logic w, input logic ld,
                       input logic [4:0] s, input logic su, input logic [4:0] t,
                       input logic tu);
    id_valid = v; dest = dst; we = w; is_load = ld;
    rs_a = s; rs_used = su; rt_a = t; rt_used = tu;
    is_ll = 1'b0; is_sc = 1'b0; is_store = 1'b0; flush = 1'b0;
    rand_data();
  endtask

  // Checks both DUTs against the model during the low phase, then advances one cycle.
  task automatic step();
    logic [31:0] ers, ert, g_rs, g_rt, g_cnt;
    logic        hrs, hrt, g_st, g_at, g_mk, iss;
    if (!rst_n) model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      src_exp(d, rs_a, rs_rf, ers, hrs);
      src_exp(d, rt_a, rt_rf, ert, hrt);
      e_stall[d] = id_valid && !flush && ((hrs && rs_used) || (hrt && rt_used));
      g_rs  = (d == 0) ? rs0 : rs1;
      g_rt  = (d == 0) ? rt0 : rt1;
      g_cnt = (d == 0) ? cnt0 : cnt1;
      g_st  = (d == 0) ? stall0 : stall1;
      g_at  = (d == 0) ? atom0 : atom1;
      g_mk  = (d == 0) ? mask0 : mask1;
      // Operand is don't-care while its producer load is still in flight.
      if (!hrs) chk("rs_data", d, g_rs, ers);
      if (!hrt) chk("rt_data", d, g_rt, ert);
      chk("stall", d, 32'(g_st), 32'(e_stall[d]));
      chk("atomic_id", d, 32'(g_at), 32'(LLSC && mlink[d]));
      chk("sc_mask", d, 32'(g_mk), 32'(LLSC && is_sc && !mlink[d]));
      chk("stall_count", d, g_cnt, mcnt[d]);
    end
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        iss = id_valid && !e_stall[d] && !flush;
        if (e_stall[d] && mcnt[d] != 32'hFFFF_FFFF) mcnt[d] = mcnt[d] + 32'd1;
        for (int i = 3; i > 0; i--) begin
          mv[d][i] = mv[d][i-1];
          md[d][i] = md[d][i-1];
          ml[d][i] = ml[d][i-1];
        end
        mv[d][0] = iss && we && dest != 5'd0;
        md[d][0] = dest;
        ml[d][0] = is_load;
        if (iss) begin
          if (!mlink[d] && is_ll) mlink[d] = 1'b1;
          else if (mlink[d] && (is_sc || is_store)) mlink[d] = 1'b0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    step();
    is_sc = 1'b1;           // SC mask passes through while in reset
    step();
    is_sc = 1'b0;
    rst_n = 1'b1;

    // Load-use: LW r8, then ADDU reading r8.
    instr(1, 8, 1, 1, 0, 0, 0, 0);
    step();
    instr(1, 3, 1, 0, 8, 1, 0, 0);
    #1;
    chk("lw_use_stall", 0, 32'(stall0), 1);
    chk("lw_use_stall", 1, 32'(stall1), 1);
    step();
    rand_data();
    #1;
    chk("lw_fwd_stage1", 0, rs0, sd[63:32]);
    chk("lw_stall_count", 0, cnt0, 1);
    chk("lat3_still_stall", 1, 32'(stall1), 1);
    step();
    rand_data();
    step();
    rand_data();
    #1;
    chk("lat3_released", 1, 32'(stall1), 0);
    chk("lat3_fwd_stage3", 1, rs1, sd[127:96]);
    chk("lat3_stall_count", 1, cnt1, 3);
    step();

    // ALU result forwarding from EX, then from the next stage.
    instr(1, 9, 1, 0, 0, 0, 0, 0);
    step();
    instr(1, 0, 0, 0, 0, 0, 9, 1);
    #1;
    chk("alu_fwd_stage0", 0, rt0, sd[31:0]);
    step();
    instr(1, 9, 1, 0, 0, 0, 0, 0);
    step();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    instr(1, 0, 0, 0, 0, 0, 9, 1);
    #1;
    chk("alu_fwd_stage1", 0, rt0, sd[63:32]);
    step();

    // Two producers of r10: youngest wins. Writer of r0 never forwards.
    instr(1, 10, 1, 0, 0, 0, 0, 0);
    step();
    instr(1, 10, 1, 0, 0, 0, 0, 0);
    step();
    instr(1, 0, 0, 0, 10, 1, 0, 0);
    #1;
    chk("youngest_wins", 0, rs0, sd[31:0]);
    step();
    instr(1, 0, 1, 1, 0, 0, 0, 0);
    step();
    instr(1, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("r0_no_fwd", 0, rs0, rs_rf);
    chk("r0_no_stall", 0, 32'(stall0), 0);
    step();

    // LL then SC.
    instr(1, 4, 1, 1, 0, 0, 0, 0); is_ll = 1'b1;
    step();
    instr(1, 5, 1, 0, 0, 0, 0, 0); is_sc = 1'b1;
    #1;
    chk("ll_sc_mask", 0, 32'(mask0), 0);
    chk("ll_sc_atomic", 0, 32'(atom0), 32'(LLSC));
    step();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("after_sc_atomic", 0, 32'(atom0), 0);
    step();
    // LL, SW, SC.
    instr(1, 4, 1, 1, 0, 0, 0, 0); is_ll = 1'b1;
    step();
    instr(1, 0, 0, 0, 0, 0, 0, 0); is_store = 1'b1;
    step();
    instr(1, 5, 1, 0, 0, 0, 0, 0); is_sc = 1'b1;
    #1;
    chk("ll_sw_sc_mask", 0, 32'(mask0), 32'(LLSC));
    step();
    // Flushed LL must not link.
    instr(1, 4, 1, 1, 0, 0, 0, 0); is_ll = 1'b1; flush = 1'b1;
    step();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("flush_ll_atomic", 0, 32'(atom0), 0);
    step();

    // Random traffic on a small register set to provoke many matches.
    for (int n = 0; n < 400; n++) begin
      instr(($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
            5'($urandom_range(0, 3)), 1'($urandom));
      case ($urandom_range(0, 7))
        0: is_ll = 1'b1;
        1: is_sc = 1'b1;
        2: is_store = 1'b1;
        default: ;
      endcase
      flush = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1'b1;
    instr(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Counter saturation: preload near the top, then stall several times.
    force dut.stall_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.stall_count_q;
    mcnt[0] = 32'hFFFF_FFFE;
    for (int n = 0; n < 3; n++) begin
      instr(1, 8, 1, 1, 0, 0, 0, 0);
      step();
      instr(1, 3, 1, 0, 8, 1, 0, 0);
      step();
      step();
    end
    #1;
    chk("count_saturated", 0, cnt0, 32'hFFFF_FFFF);

    // Reset in the middle of a stall.
    instr(1, 8, 1, 1, 0, 0, 0, 0);
    step();
    instr(1, 3, 1, 0, 8, 1, 0, 0);
    #1;
    chk("pre_reset_stall", 0, 32'(stall0), 1);
    rst_n = 1'b0;
    #1;
    chk("reset_stall", 0, 32'(stall0), 0);
    chk("reset_count", 0, cnt0, 0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_reset_no_stall", 0, 32'(stall0), 0);
    chk("post_reset_rf", 0, rs0, rs_rf);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter DATA_W, default 32, register data width.
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter FWD_STAGES, default 2, range 1..4, downstream stages eligible for forwarding (index 0 = EX).
REQ-004 Parameter LOAD_LAT, default 1, range 1..FWD_STAGES, stages a load travels past EX before its data is forwardable.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 id_valid  in  1  decode slot holds a real instruction.
REQ-008 id_rs_addr, id_rt_addr  in  ADDR_W each  source register addresses.
REQ-009 id_rs_used, id_rt_used  in  1 each  instruction actually reads that source.
REQ-010 id_rs_data_in, id_rt_data_in  in  DATA_W each  register-file read data.
REQ-011 id_dest_addr  in  ADDR_W; id_reg_we  in  1  destination and write enable.
REQ-012 id_is_load, id_is_ll, id_is_sc, id_is_store  in  1 each  instruction class flags.
REQ-013 flush  in  1  squash the instruction in decode this cycle.
REQ-014 stage_data  in  FWD_STAGES*DATA_W  result per stage, stage i at bits [i*DATA_W +: DATA_W].
REQ-015 rs_data, rt_data  out  DATA_W each  forwarded operands.
REQ-016 stall  out  1  hold decode and fetch this cycle.
REQ-017 atomic_id  out  1  load-link reservation active.
REQ-018 mem_sc_mask_id  out  1  SC in decode must not store.
REQ-019 stall_count  out  32  saturating count of stalled cycles.

Function
REQ-020 Scoreboard: FWD_STAGES entries {valid, dest, is_load}, entry 0 = instruction now in EX.
REQ-021 Every cycle entries shift i -> i+1; last entry discarded.
REQ-022 Issue = id_valid & ~stall & ~flush; on issue entry 0 loads {id_reg_we & dest!=0, id_dest_addr, id_is_load}; otherwise entry 0 becomes invalid (bubble).
REQ-023 Source match at entry i: valid & dest==src addr & src addr!=0; lowest index match wins.
REQ-024 Matched entry with is_load and i < LOAD_LAT is a hazard; stall = id_valid & ~flush & (hazard on any used source).
REQ-025 Matched non-hazard: operand = stage_data slice i; no match: operand = register-file input; purely combinational, zero latency.
REQ-026 Address 0 never forwards and never stalls.
REQ-027 stall_count increments by 1 each cycle stall=1; holds at 32'hFFFF_FFFF.
REQ-028 Link FSM states IDLE, LINKED; atomic_id = (state==LINKED).
REQ-029 IDLE -> LINKED on issued LL; LINKED -> IDLE on issued SC or store; issued LL in LINKED stays LINKED.
REQ-030 mem_sc_mask_id = id_is_sc & (state==IDLE), evaluated before the SC's own transition.
REQ-031 Flush: no scoreboard push, no FSM transition, stall forced 0.

Reset
REQ-032 rst_n low asynchronously clears all entry valids, FSM to IDLE, stall_count to 0.
REQ-033 During reset: stall=0, atomic_id=0, mem_sc_mask_id=id_is_sc, operands pass register-file data.
REQ-034 Reset mid-stall discards the pending hazard; first cycle after release sees an empty scoreboard.

Configuration
REQ-035 Macro HAZARD_LLSC_EN: defined -> link FSM per REQ-028..030.
REQ-036 Undefined -> no FSM flops; atomic_id=0, mem_sc_mask_id=0; id_is_ll/id_is_sc ignored.

Structure
REQ-037 Shared package mips_hazard_pkg holds scoreboard entry typedef, FSM state enum, FWD_STAGES/LOAD_LAT limits.
REQ-038 One sub-module fwd_mux: per-source priority match and select, instantiated twice (rs, rt).

Verification
REQ-039 Defaults; issue LW dest=8, next cycle ADDU rs=8 -> stall=1 one cycle, then rs_data=stage_data[1], stall_count=1.
REQ-040 ADDIU dest=9 then consumer rt=9 -> no stall, rt_data=stage_data[0]; consumer rt=9 two cycles later -> rt_data=stage_data[1].
REQ-041 Entry 0 and entry 1 both dest=10, consumer rs=10 -> stage_data[0] selected; dest=0 writer, consumer rs=0 -> register-file data, no stall.
REQ-042 LL, SC -> SC mask 0, atomic_id 1 then 0; LL, SW, SC -> SC mask 1; flush on LL -> atomic_id stays 0.
REQ-043 Force 2^32+3 stall cycles -> stall_count=32'hFFFF_FFFF; rst_n low mid-stall -> stall=0, count=0 immediately.
REQ-044 FWD_STAGES=4, LOAD_LAT=3: load then dependent -> 3 stall cycles, operand from stage_data[3].
